// File: rtl/gb_hdma_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// gb_hdma_pkg : shared state encoding and register offsets for the CGB VRAM DMA
// Revision    : 1.0
// ----------------------------------------------------------------------------
package gb_hdma_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WAIT_HB = 3'd1,
    RD_REQ  = 3'd2,
    WR_REQ  = 3'd3,
    BLK_END = 3'd4
  } hdma_state_t;

  localparam logic [7:0]  HDMA1     = 8'h51;
  localparam logic [7:0]  HDMA2     = 8'h52;
  localparam logic [7:0]  HDMA3     = 8'h53;
  localparam logic [7:0]  HDMA4     = 8'h54;
  localparam logic [7:0]  HDMA5     = 8'h55;
  localparam logic [15:0] VRAM_BASE = 16'h8000;

endpackage
`default_nettype wire

// File: rtl/gb_hdma_controller.sv
`default_nettype none
// ----------------------------------------------------------------------------
// gb_hdma_controller : FF51-FF55 register file and GDMA/HDMA byte mover into VRAM
// Revision           : 1.0
// ----------------------------------------------------------------------------
module gb_hdma_controller #(
  parameter int          BLOCK_BYTES = 16,
  parameter logic [15:0] VRAM_BASE   = 16'h8000
) (
  input  logic        clock,
  input  logic        rst,
  input  logic [15:0] addr_bus,
  input  logic [7:0]  data_in,
  input  logic        we,
  input  logic        cgb,
  input  logic        hblank,
  input  logic        lcd_on,
  output logic [7:0]  reg_data_out,
  output logic        reg_hit,
  output logic        cpu_stall,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata,
  input  logic        mem_ack,
  output logic        active
);
  import gb_hdma_pkg::*;

  localparam int BLK_W = $clog2(BLOCK_BYTES);

  hdma_state_t state;
  logic [15:0] src;
  logic [12:0] dst;
  logic [6:0]  remaining;
  logic        mode;
  logic        done_flag;
  logic        cancel_pend;
  logic        hb_prev;
  logic [7:0]  byte_q;

  logic       io_page;
  logic       wr_en;
  logic       wr55;
  logic       cfg_ok;
  logic       cancel_wr;
  logic       hb_rise;
  logic       blk_last;

  assign io_page   = (addr_bus[15:8] == 8'hFF);
  assign reg_hit   = cgb && io_page && (addr_bus[7:0] >= HDMA1) && (addr_bus[7:0] <= HDMA5);
  assign wr_en     = we && cgb && io_page;
  assign wr55      = wr_en && (addr_bus[7:0] == HDMA5);
  assign cfg_ok    = (state == IDLE) || (state == WAIT_HB);
  assign cancel_wr = wr55 && mode && !data_in[7];
  assign hb_rise   = hblank && !hb_prev;
  assign blk_last  = &dst[BLK_W-1:0];

  assign reg_data_out = (reg_hit && addr_bus[7:0] == HDMA5) ? {done_flag, remaining} : 8'hFF;

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      src         <= 16'hFFF0;
      dst         <= 13'h1FF0;
      remaining   <= 7'h7F;
      mode        <= 1'b0;
      done_flag   <= 1'b1;
      cancel_pend <= 1'b0;
      hb_prev     <= 1'b0;
      byte_q      <= 8'h00;
    end else begin
      hb_prev <= hblank;

      if (wr_en && cfg_ok) begin
        case (addr_bus[7:0])
          HDMA1:   src[15:8] <= data_in;
          HDMA2:   src[7:0]  <= {data_in[7:4], 4'h0};
          HDMA3:   dst[12:8] <= data_in[4:0];
          HDMA4:   dst[7:0]  <= {data_in[7:4], 4'h0};
          default: ;
        endcase
      end

      case (state)
        IDLE: begin
          if (wr55) begin
            remaining   <= data_in[6:0];
            mode        <= data_in[7];
            done_flag   <= 1'b0;
            cancel_pend <= 1'b0;
            state       <= data_in[7] ? WAIT_HB : RD_REQ;
          end
        end
        WAIT_HB: begin
          // Between blocks nothing is in flight, so a cancel lands at once.
          if (cancel_wr) begin
            done_flag <= 1'b1;
            state     <= IDLE;
          end else if (hb_rise || !lcd_on) begin
            state <= RD_REQ;
          end
        end
        RD_REQ: begin
          if (cancel_wr) cancel_pend <= 1'b1;
          if (mem_ack) begin
            byte_q <= mem_rdata;
            state  <= WR_REQ;
          end
        end
        WR_REQ: begin
          if (cancel_wr) cancel_pend <= 1'b1;
          if (mem_ack) begin
            src   <= src + 16'd1;
            dst   <= dst + 13'd1;
            state <= blk_last ? BLK_END : RD_REQ;
          end
        end
        BLK_END: begin
          // FF55 writes landing here are dropped; the block outcome wins.
          if (remaining == 7'd0 || dst == 13'd0 || cancel_pend) begin
            done_flag   <= 1'b1;
            remaining   <= 7'h7F;
            cancel_pend <= 1'b0;
            state       <= IDLE;
          end else begin
            remaining <= remaining - 7'd1;
            state     <= mode ? WAIT_HB : RD_REQ;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    mem_req   = 1'b0;
    mem_wr    = 1'b0;
    mem_addr  = 16'h0000;
    mem_wdata = 8'h00;
    case (state)
      RD_REQ: begin
        mem_req  = 1'b1;
        mem_addr = src;
      end
      WR_REQ: begin
        mem_req   = 1'b1;
        mem_wr    = 1'b1;
        mem_addr  = VRAM_BASE | {3'b000, dst};
        mem_wdata = byte_q;
      end
      default: ;
    endcase
  end

  assign cpu_stall = (state == RD_REQ) || (state == WR_REQ) || (state == BLK_END);
  assign active    = (state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_gb_hdma_controller.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_gb_hdma_controller : directed bench for the CGB VRAM DMA sequencer
// Revision              : 1.0
// ----------------------------------------------------------------------------
module tb_gb_hdma_controller;

  logic        clock = 1'b0;
  logic        rst   = 1'b1;
  logic [15:0] addr_bus = 16'h0000;
  logic [7:0]  data_in  = 8'h00;
  logic        we = 1'b0, cgb = 1'b1, hblank = 1'b0, lcd_on = 1'b1;
  logic [7:0]  reg_data_out, mem_wdata, mem_rdata;
  logic        reg_hit, cpu_stall, mem_req, mem_wr, mem_ack, active;
  logic [15:0] mem_addr;

  int checks = 0;
  int errors = 0;
  int lat = 0;
  int wcnt = 0;
  int req_drop = 0;
  logic        prev_pend = 1'b0;
  logic [15:0] prev_addr = 16'h0000;

  logic [15:0] rd_q[$];
  logic [15:0] wa_q[$];
  logic [7:0]  wd_q[$];

  gb_hdma_controller dut (
    .clock(clock), .rst(rst), .addr_bus(addr_bus), .data_in(data_in), .we(we),
    .cgb(cgb), .hblank(hblank), .lcd_on(lcd_on), .reg_data_out(reg_data_out),
    .reg_hit(reg_hit), .cpu_stall(cpu_stall), .mem_req(mem_req), .mem_wr(mem_wr),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ack(mem_ack), .active(active)
  );

  always #5 clock = ~clock;

  function automatic logic [7:0] src_byte(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction

  // Memory controller model: ack after lat idle cycles, log each completed access.
  always @(posedge clock or posedge rst) begin
    if (rst) begin
      mem_ack   <= 1'b0;
      mem_rdata <= 8'h00;
      wcnt      <= 0;
    end else begin
      mem_ack <= 1'b0;
      if (mem_req && !mem_ack) begin
        if (wcnt >= lat) begin
          mem_ack <= 1'b1;
          wcnt    <= 0;
          if (mem_wr) begin
            wa_q.push_back(mem_addr);
            wd_q.push_back(mem_wdata);
          end else begin
            rd_q.push_back(mem_addr);
            mem_rdata <= src_byte(mem_addr);
          end
        end else begin
          wcnt <= wcnt + 1;
        end
      end
    end
  end

  always @(negedge clock) begin
    if (rst) begin
      prev_pend <= 1'b0;
    end else begin
      if (prev_pend && (!mem_req || mem_addr != prev_addr)) req_drop++;
      prev_pend <= mem_req && !mem_ack;
      prev_addr <= mem_addr;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    @(negedge clock);
    addr_bus = {8'hFF, a};
    data_in  = d;
    we       = 1'b1;
    @(negedge clock);
    we       = 1'b0;
    addr_bus = 16'h0000;
  endtask

  task automatic rd_check(input string name, input logic [7:0] a, input logic [7:0] exp);
    @(negedge clock);
    addr_bus = {8'hFF, a};
    #1;
    check(name, reg_data_out, exp);
    addr_bus = 16'h0000;
  endtask

  task automatic clear_logs();
    rd_q.delete();
    wa_q.delete();
    wd_q.delete();
  endtask

  task automatic setup(input logic [15:0] s, input logic [12:0] d);
    wr(8'h51, s[15:8]);
    wr(8'h52, s[7:0]);
    wr(8'h53, {3'b000, d[12:8]});
    wr(8'h54, d[7:0]);
  endtask

  task automatic wait_idle(input string name, output int stall_bad);
    int n = 0;
    stall_bad = 0;
    while (active && n < 2000) begin
      if (!cpu_stall) stall_bad++;
      @(negedge clock);
      n++;
    end
    check(name, {31'd0, active}, 32'd0);
  endtask

  task automatic hb_block(input bit expect_xfer);
    int n;
    @(negedge clock);
    hblank = 1'b1;
    if (expect_xfer) begin
      n = 0;
      do begin @(negedge clock); n++; end while (!cpu_stall && n < 20);
      check("hblank start", {31'd0, cpu_stall}, 32'd1);
      n = 0;
      while (cpu_stall && n < 500) begin @(negedge clock); n++; end
      check("block end", {31'd0, cpu_stall}, 32'd0);
    end else begin
      repeat (10) @(negedge clock);
    end
    hblank = 1'b0;
    repeat (3) @(negedge clock);
  endtask

  task automatic check_seq(input string name, input logic [15:0] rbase,
                           input logic [15:0] wbase, input int cnt);
    int bad = 0;
    check({name, " rd count"}, rd_q.size(), cnt);
    check({name, " wr count"}, wa_q.size(), cnt);
    for (int i = 0; i < cnt && i < rd_q.size() && i < wa_q.size(); i++) begin
      if (rd_q[i] != rbase + 16'(i)) bad++;
      if (wa_q[i] != wbase + 16'(i)) bad++;
      if (wd_q[i] != src_byte(rbase + 16'(i))) bad++;
    end
    check({name, " seq errors"}, bad, 0);
  endtask

  typedef struct packed {
    logic [7:0] a;
    logic       cg;
    logic       hit;
    logic [7:0] data;
  } vec_t;

  vec_t tbl[8];

  initial begin
    int sb;
    tbl[0] = '{8'h51, 1'b1, 1'b1, 8'hFF};
    tbl[1] = '{8'h52, 1'b1, 1'b1, 8'hFF};
    tbl[2] = '{8'h53, 1'b1, 1'b1, 8'hFF};
    tbl[3] = '{8'h54, 1'b1, 1'b1, 8'hFF};
    tbl[4] = '{8'h55, 1'b1, 1'b1, 8'hFF};
    tbl[5] = '{8'h50, 1'b1, 1'b0, 8'hFF};
    tbl[6] = '{8'h56, 1'b1, 1'b0, 8'hFF};
    tbl[7] = '{8'h55, 1'b0, 1'b0, 8'hFF};

    repeat (3) @(negedge clock);
    rst = 1'b0;
    @(negedge clock);

    // Reset state and register decode.
    check("reset active", {31'd0, active}, 32'd0);
    check("reset mem_req", {31'd0, mem_req}, 32'd0);
    check("reset stall", {31'd0, cpu_stall}, 32'd0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      cgb = tbl[i].cg;
      addr_bus = {8'hFF, tbl[i].a};
      #1;
      check($sformatf("vec%0d hit", i), {31'd0, reg_hit}, {31'd0, tbl[i].hit});
      check($sformatf("vec%0d data", i), {24'd0, reg_data_out}, {24'd0, tbl[i].data});
    end
    cgb = 1'b1;
    addr_bus = 16'h0000;

    // 1. GDMA two blocks.
    clear_logs();
    setup(16'hC000, 13'h0000);
    check("gdma idle before start", {31'd0, active}, 32'd0);
    wr(8'h55, 8'h01);
    check("gdma stall on entry", {31'd0, cpu_stall}, 32'd1);
    wait_idle("gdma finish", sb);
    check("gdma stall gaps", sb, 0);
    check_seq("gdma", 16'hC000, 16'h8000, 32);
    rd_check("gdma ff55", 8'h55, 8'hFF);

    // 2. HDMA three blocks.
    clear_logs();
    lat = 1;
    setup(16'hD100, 13'h0200);
    wr(8'h55, 8'h82);
    repeat (5) @(negedge clock);
    check("hdma waits", {31'd0, active, cpu_stall}, 32'd2);
    check("hdma no early req", rd_q.size(), 0);
    hb_block(1'b1);
    rd_check("hdma ff55 blk1", 8'h55, 8'h01);
    check("hdma blk1 count", wa_q.size(), 16);
    hb_block(1'b1);
    rd_check("hdma ff55 blk2", 8'h55, 8'h00);
    hb_block(1'b1);
    rd_check("hdma ff55 blk3", 8'h55, 8'hFF);
    check("hdma idle", {31'd0, active}, 32'd0);
    hb_block(1'b0);
    check_seq("hdma", 16'hD100, 16'h8200, 48);

    // 3. Cancel in WAIT_HB.
    clear_logs();
    lat = 0;
    setup(16'hC000, 13'h0000);
    wr(8'h55, 8'h85);
    hb_block(1'b1);
    hb_block(1'b1);
    wr(8'h55, 8'h00);
    check("cancel idle", {31'd0, active}, 32'd0);
    rd_check("cancel ff55", 8'h55, 8'h83);
    hb_block(1'b0);
    check("cancel no more", rd_q.size(), 32);

    // 4. Cancel during WR_REQ of byte 5.
    begin
      int n = 0;
      clear_logs();
      lat = 3;
      req_drop = 0;
      setup(16'hC400, 13'h0400);
      wr(8'h55, 8'h85);
      @(negedge clock);
      hblank = 1'b1;
      while (!(mem_req && mem_wr && !mem_ack && rd_q.size() == 5) && n < 300) begin
        @(negedge clock);
        n++;
      end
      check("midblk reached byte5", {31'd0, mem_wr}, 32'd1);
      wr(8'h55, 8'h00);
      wait_idle("midblk finish", sb);
      hblank = 1'b0;
      check("midblk stall gaps", sb, 0);
      check_seq("midblk", 16'hC400, 16'h8400, 16);
      rd_check("midblk ff55", 8'h55, 8'hFF);
      check("midblk req held", req_drop, 0);
      hb_block(1'b0);
      check("midblk no more", wa_q.size(), 16);
    end

    // 5. Destination wraps to zero.
    clear_logs();
    lat = 0;
    setup(16'hC000, 13'h1FF0);
    wr(8'h55, 8'h03);
    wait_idle("wrap finish", sb);
    check_seq("wrap", 16'hC000, 16'h9FF0, 16);
    rd_check("wrap ff55", 8'h55, 8'hFF);

    // 6. Async reset mid-GDMA, then CGB disabled.
    clear_logs();
    lat = 5;
    setup(16'hC000, 13'h0000);
    wr(8'h55, 8'h01);
    check("pre-reset req", {31'd0, mem_req}, 32'd1);
    rst = 1'b1;
    #1;
    check("async reset req", {31'd0, mem_req}, 32'd0);
    check("async reset stall", {31'd0, cpu_stall}, 32'd0);
    check("async reset active", {31'd0, active}, 32'd0);
    repeat (3) @(negedge clock);
    rst = 1'b0;
    lat = 0;
    rd_check("post-reset ff55", 8'h55, 8'hFF);
    clear_logs();
    cgb = 1'b0;
    @(negedge clock);
    addr_bus = 16'hFF55;
    #1;
    check("cgb0 hit", {31'd0, reg_hit}, 32'd0);
    wr(8'h55, 8'h01);
    repeat (20) @(negedge clock);
    check("cgb0 active", {31'd0, active}, 32'd0);
    check("cgb0 no req", rd_q.size(), 0);
    cgb = 1'b1;

    check("overall req held", req_drop, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/gb_hdma_controller.md
Name: gb_hdma_controller

Overview:
CGB VRAM DMA sequencer. Owns registers FF51-FF55 and runs General-Purpose (GDMA) and HBlank (HDMA) transfers into VRAM through a request/ack byte port into the memory controller. Stalls the CPU while bytes move. Sits beside the OAM DMA engine, between the CPU bus decode and the memory controller's shared ROM/WRAM/cart-RAM/VRAM path.

Parameters:
BLOCK_BYTES, 16, bytes moved per HBlank block; also the length granularity.
VRAM_BASE, 16'h8000, base added to the 13-bit destination offset.

Ports:
clock  in  1  system clock
rst  in  1  asynchronous, active-high reset
addr_bus  in  16  CPU address
data_in  in  8  CPU write data
we  in  1  CPU write strobe, one cycle per write
cgb  in  1  CGB mode; 0 disables the block
hblank  in  1  PPU mode-0 level
lcd_on  in  1  LCDC bit 7
reg_data_out  out  8  read data for FF51-FF55
reg_hit  out  1  addr_bus is in FF51-FF55 and cgb=1
cpu_stall  out  1  holds the CPU while bytes transfer
mem_req  out  1  byte access request
mem_wr  out  1  0 = read source, 1 = write VRAM
mem_addr  out  16  access address
mem_wdata  out  8  write data
mem_rdata  in  8  read data, valid on the mem_ack cycle
mem_ack  in  1  one-cycle completion pulse
active  out  1  transfer in progress

Behaviour:
- Reset (async): state IDLE; src=16'hFFF0, dst=13'h1FF0, remaining=7'h7F, mode=0, done_flag=1. Outputs: mem_req=0, mem_wr=0, mem_addr=0, mem_wdata=0, cpu_stall=0, active=0.
- Register writes (we, cgb=1, state IDLE or WAIT_HB only):
  - FF51 sets src[15:8].
  - FF52 sets src[7:4]; src[3:0] is forced to 0.
  - FF53 sets dst[12:8] from data_in[4:0].
  - FF54 sets dst[7:4]; dst[3:0] is forced to 0.
- FF55 write:
  - While IDLE: remaining = data_in[6:0], mode = data_in[7], done_flag=0. Go to RD_REQ if mode=0; go to WAIT_HB if mode=1.
  - While an HDMA is active and data_in[7]=0: cancel. Cancel takes effect at the next block boundary or immediately in WAIT_HB; then done_flag=1 and go to IDLE.
  - While an HDMA is active and data_in[7]=1: ignored.
  - While a GDMA is active: ignored.
- Register reads: reg_data_out = FF55 ? {done_flag, remaining} : 8'hFF. FF51-FF54 are write-only. When cgb=0, reg_hit=0 and writes are ignored.
- WAIT_HB: advance to RD_REQ on the rising edge of hblank (registered previous value). When lcd_on=0, advance on the next cycle.
- RD_REQ: mem_req=1, mem_wr=0, mem_addr=src. Hold until mem_ack. On ack, latch mem_rdata and go to WR_REQ.
- WR_REQ: mem_req=1, mem_wr=1, mem_addr = VRAM_BASE | dst, mem_wdata = latched byte. On ack:
  - src += 1, wrapping 16-bit.
  - dst += 1, 13-bit.
  - If dst[3:0] was 4'hF, go to BLK_END; otherwise go to RD_REQ.
- BLK_END (one cycle):
  - If remaining==0, or dst wrapped to 0, or a cancel is pending: done_flag=1, remaining=7'h7F, go to IDLE.
  - Otherwise remaining -= 1. GDMA goes to RD_REQ; HDMA goes to WAIT_HB.
- mem_req never drops before mem_ack; a cancel never aborts a byte mid-handshake.
- cpu_stall=1 in RD_REQ, WR_REQ and BLK_END. It asserts combinationally in the same cycle the state is entered. It is 0 in WAIT_HB, so the CPU runs between blocks.
- active=1 in every state except IDLE.
- Simultaneous FF55 write and block completion in the same cycle: the completion wins and the write is dropped.
- Latency: 2*BLOCK_BYTES mem_ack cycles plus 1 per block.

Decomposition:
Package gb_hdma_pkg holds:
- the state enum hdma_state_t {IDLE, WAIT_HB, RD_REQ, WR_REQ, BLK_END};
- register offset constants HDMA1..HDMA5 (8'h51-8'h55);
- VRAM_BASE.

No sub-module is needed. The register file and the FSM stay in one module.

Test Plan:
1. GDMA: write FF51=C0, FF52=00, FF53=00, FF54=00, FF55=01 → 32 reads C000-C01F and 32 writes 8000-801F, cpu_stall high throughout, FF55 then reads FF.
2. HDMA: FF55=82 → one 16-byte block per hblank rise. FF55 reads 01 after block 1 and 00 after block 2; reads FF after block 3, and no transfer happens on the 4th hblank.
3. Cancel: HDMA with FF55=85. After 2 blocks, write FF55=00 while in WAIT_HB → IDLE, FF55 reads 83, no further mem_req.
4. Cancel mid-block: write FF55=00 during WR_REQ of byte 5 → the block finishes all 16 bytes, then IDLE. mem_req is not dropped before ack.
5. Destination wrap: FF53=1F, FF54=F0, FF55=03 → one block to 9FF0-9FFF, then terminate with FF55=FF.
6. Async reset asserted mid-GDMA with mem_req=1 → same cycle mem_req=0, cpu_stall=0, active=0. cgb=0 write to FF55 → no transfer, reg_hit=0.
